// File: rtl/sseg_scan_ctrl_if.sv
// rtl/sseg_scan_ctrl_if.sv - frame write handshake between a requester and sseg_scan_ctrl
interface sseg_scan_ctrl_if;
  logic        wr_valid;
  logic [55:0] wr_data;
  logic        ready;

  modport master (
    output wr_valid,
    output wr_data,
    input  ready
  );

  modport slave (
    input  wr_valid,
    input  wr_data,
    output ready
  );
endinterface

// File: rtl/sseg_scan_ctrl.sv
// rtl/sseg_scan_ctrl.sv - 8-digit seven-segment scan controller with double-buffered frames
// Define SSEG_DIM_EN to add the brightness port and PWM anode dimming.
module sseg_scan_ctrl #(
  parameter int DIV_BITS = 17
) (
  input  logic                   clk,
  input  logic                   reset,
  sseg_scan_ctrl_if.slave        wr,
`ifdef SSEG_DIM_EN
  input  logic [2:0]             brightness,
`endif
  output logic [6:0]             sseg,
  output logic [7:0]             an,
  output logic                   frame_tick
);

  logic [DIV_BITS-1:0] presc_q, presc_d;
  logic [2:0]          digit_q, digit_d;
  logic                pending_q, pending_d;
  logic [55:0]         active_q, active_d;
  logic [55:0]         shadow_q, shadow_d;
  logic [7:0]          an_q, an_d;
  logic [6:0]          sseg_q, sseg_d;
  logic                tick_q, tick_d;

  logic slot_end;
  logic frame_end;
  logic xfer;
  logic lit;

  assign wr.ready = ~pending_q;

  always_comb begin
    slot_end  = &presc_q;
    frame_end = slot_end && (digit_q == 3'd7);
    xfer      = wr.wr_valid && !pending_q;

    presc_d   = presc_q + DIV_BITS'(1);
    digit_d   = slot_end ? digit_q + 3'd1 : digit_q;

    active_d  = active_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;

    // Commit needs pending=1 and a transfer needs pending=0, so a transfer on
    // a boundary cycle waits for the following boundary.
    if (frame_end && pending_q) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
    end else if (xfer) begin
      shadow_d  = wr.wr_data;
      pending_d = 1'b1;
    end

`ifdef SSEG_DIM_EN
    lit = (presc_q[DIV_BITS-1 -: 3] <= brightness);
`else
    lit = 1'b1;
`endif

    an_d   = lit ? ~(8'd1 << digit_q) : 8'hFF;
    sseg_d = active_q[7*digit_q +: 7];
    tick_d = frame_end;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q   <= '0;
      digit_q   <= 3'd0;
      pending_q <= 1'b0;
      active_q  <= '1;
      shadow_q  <= '1;
      an_q      <= 8'hFF;
      sseg_q    <= 7'h7F;
      tick_q    <= 1'b0;
    end else begin
      presc_q   <= presc_d;
      digit_q   <= digit_d;
      pending_q <= pending_d;
      active_q  <= active_d;
      shadow_q  <= shadow_d;
      an_q      <= an_d;
      sseg_q    <= sseg_d;
      tick_q    <= tick_d;
    end
  end

  assign an         = an_q;
  assign sseg       = sseg_q;
  assign frame_tick = tick_q;

endmodule

// File: doc/sseg_scan_ctrl.md
SSEG_SCAN_CTRL -- requirements
Module: sseg_scan_ctrl

Interface
REQ-001 Parameter: DIV_BITS, default 17, scan prescaler width. Each digit slot lasts 2^DIV_BITS clk cycles. Legal range 4..24.
REQ-002 clk  input  1  system clock; all logic on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 wr_valid  input  1  requester offers a new 8-digit frame.
REQ-005 wr_data  input  56  digit i pattern at bits [7i+6:7i], order gfedcba, active-low; digit 0 is rightmost.
REQ-006 ready  output  1  controller can accept a frame.
REQ-007 sseg  output  7  active-low segment drive.
REQ-008 an  output  8  active-low anode drive; digit i uses anode bit i.
REQ-009 frame_tick  output  1  one-cycle pulse per completed scan frame.
REQ-010 brightness  input  3  dimming level; present only when SSEG_DIM_EN is defined.

Function
REQ-011 The prescaler (DIV_BITS wide) increments every cycle and wraps to 0.
REQ-012 When the prescaler is all-ones, digit index (3 bits) increments and wraps from 7 to 0.
REQ-013 Frame boundary is defined as: prescaler all-ones AND digit index = 7.
REQ-014 The block holds two 56-bit buffers: active (displayed) and shadow (pending), plus a pending flag.
REQ-015 ready SHALL equal NOT pending, combinationally.
REQ-016 Transfer occurs on a cycle with wr_valid=1 and ready=1. On transfer, the shadow buffer captures wr_data and pending sets on the next edge.
REQ-017 wr_data is ignored when no transfer occurs.
REQ-018 At a frame boundary with pending=1: active takes shadow and pending clears on the same edge. ready returns to 1 the following cycle.
REQ-019 A transfer on a frame boundary cycle (pending=0) is not committed at that boundary; it commits at the next boundary.
REQ-020 The display never shows a partially updated frame; active changes only at frame boundaries.
REQ-021 an and sseg are registered with 1-cycle latency:
- an = ~(1 << digit)
- sseg = active[digit]
- both computed from the prior cycle's digit index and active buffer.
REQ-022 frame_tick is registered; it is 1 the cycle after a frame boundary, otherwise 0.
REQ-023 Exactly one an bit is 0 at any time outside reset (absent dimming), so a digit change never overlaps anodes.

Reset
REQ-024 While reset=1 on a clock edge, the following values load:
- prescaler=0, digit=0, pending=0
- active and shadow = all-ones (blank)
- an=8'hFF, sseg=7'h7F, frame_tick=0
REQ-025 ready=1 during and after reset.
REQ-026 Reset mid-frame discards any pending shadow. Scanning restarts at digit 0 with a full slot.
REQ-027 Reset has priority over transfer and commit in the same cycle.

Configuration
REQ-028 Macro SSEG_DIM_EN compiles in the brightness port and PWM dimming.
REQ-029 With SSEG_DIM_EN defined, the selected anode is driven low only while prescaler[DIV_BITS-1 -: 3] <= brightness; otherwise an=8'hFF. This is also registered with 1-cycle latency. brightness=7 gives full-on.
REQ-030 Without SSEG_DIM_EN, the brightness port does not exist and the selected anode is low for the entire slot.
REQ-031 Scan timing, handshake and frame_tick are identical in both builds.

Verification (DIV_BITS=4: slot 16 cycles, frame 128 cycles)
REQ-032 Reset: hold reset 3 cycles -> an=FF, sseg=7F, ready=1, frame_tick=0.
REQ-033 Idle after reset, no writes -> an sequences FE, FD, FB, ..., 7F, each for 16 cycles. sseg=7F throughout. frame_tick pulses every 128 cycles.
REQ-034 Mid-frame transfer, wr_data with digit0=7'h09 ("H"), digit1=7'h79 ("I"), others 7F:
- ready=0 the next cycle
- display stays blank until the boundary
- afterwards, an=FE shows sseg=09 and an=FD shows sseg=79
- ready=1 the cycle after the boundary
REQ-035 wr_valid held high with a second frame while pending -> no transfer until ready rises. The second frame displays one frame after the first.
REQ-036 Transfer, then reset 5 cycles later -> after reset, all digits blank and ready=1. The shadow is never displayed.
REQ-037 SSEG_DIM_EN build, brightness=3 -> each anode is low for 8 of its 16 cycles. brightness=0 -> low for 2 cycles. brightness=7 -> low for 16 cycles.
